// File: rtl/axi_ar_burst_splitter.sv
`default_nettype none
// ============================================================================
// axi_ar_burst_splitter: re-issues AXI4 AR bursts as length/boundary-limited
// sub-bursts tagged with first/last flags.     Revision: 1.0
// ============================================================================
module axi_ar_burst_splitter #(
    parameter int AXI_ARID_WIDTH   = 1,
    parameter int AXI_ARADDR_WIDTH = 32,
    parameter int AXI_ARUSER_WIDTH = 1,
    parameter int MAX_BEATS        = 16,
    parameter int BOUNDARY         = 4096
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [AXI_ARID_WIDTH-1:0]   s_arid,
    input  logic [AXI_ARADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]                  s_arlen,
    input  logic [2:0]                  s_arsize,
    input  logic [1:0]                  s_arburst,
    input  logic                        s_arlock,
    input  logic [3:0]                  s_arcache,
    input  logic [2:0]                  s_arprot,
    input  logic [3:0]                  s_arqos,
    input  logic [3:0]                  s_arregion,
    input  logic [AXI_ARUSER_WIDTH-1:0] s_aruser,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [AXI_ARID_WIDTH-1:0]   m_arid,
    output logic [AXI_ARADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [1:0]                  m_arburst,
    output logic                        m_arlock,
    output logic [3:0]                  m_arcache,
    output logic [2:0]                  m_arprot,
    output logic [3:0]                  m_arqos,
    output logic [3:0]                  m_arregion,
    output logic [AXI_ARUSER_WIDTH-1:0] m_aruser,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic                        m_arfirst,
    output logic                        m_arlast
);

    localparam int         AW          = AXI_ARADDR_WIDTH;
    localparam int         OFF_W       = $clog2(BOUNDARY);
    localparam int         BND_W       = OFF_W + 1;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // Beats for a sub-burst starting at addr_lo with rem beats still owed.
    function automatic logic [8:0] calc_beats(
        input logic [OFF_W-1:0] addr_lo,
        input logic [8:0]       rem,
        input logic [2:0]       size,
        input logic [1:0]       burst
    );
        logic [OFF_W-1:0] offset;
        logic [BND_W-1:0] to_bnd;
        logic [8:0]       beats;
        offset = addr_lo & ~((OFF_W'(1) << size) - OFF_W'(1));
        to_bnd = (BND_W'(BOUNDARY) - {1'b0, offset}) >> size;
        beats  = rem;
        if ((burst == BURST_INCR || burst == BURST_FIXED) && beats > 9'(MAX_BEATS)) begin
            beats = 9'(MAX_BEATS);
        end
        if (burst == BURST_INCR && 16'(to_bnd) < 16'(beats)) begin
            beats = 9'(to_bnd);
        end
        return beats;
    endfunction

    state_t                      state_q;
    logic [AXI_ARID_WIDTH-1:0]   id_q;
    logic [AW-1:0]               addr_q;
    logic [7:0]                  len_q;
    logic [2:0]                  size_q;
    logic [1:0]                  burst_q;
    logic                        lock_q;
    logic [3:0]                  cache_q;
    logic [2:0]                  prot_q;
    logic [3:0]                  qos_q;
    logic [3:0]                  region_q;
    logic [AXI_ARUSER_WIDTH-1:0] user_q;
    logic [8:0]                  rem_q;
    logic                        first_q;
    logic                        last_q;

    logic [8:0]    s_rem;
    logic [8:0]    cur_beats;
    logic [8:0]    next_rem;
    logic [8:0]    beats_d;
    logic [AW-1:0] aligned;
    logic [AW-1:0] next_addr;

    // The beat count is evaluated one step ahead so m_arlen/m_arlast stay registered.
    always_comb begin
        s_rem     = {1'b0, s_arlen} + 9'd1;
        cur_beats = {1'b0, len_q} + 9'd1;
        aligned   = addr_q & ~((AW'(1) << size_q) - AW'(1));
        next_addr = (burst_q == BURST_INCR) ? aligned + (AW'(cur_beats) << size_q) : addr_q;
        next_rem  = rem_q - cur_beats;
        if (state_q == S_IDLE) begin
            beats_d = calc_beats(s_araddr[OFF_W-1:0], s_rem, s_arsize, s_arburst);
        end else begin
            beats_d = calc_beats(next_addr[OFF_W-1:0], next_rem, size_q, burst_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            lock_q   <= 1'b0;
            cache_q  <= '0;
            prot_q   <= '0;
            qos_q    <= '0;
            region_q <= '0;
            user_q   <= '0;
            rem_q    <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (s_arvalid) begin
                        id_q     <= s_arid;
                        addr_q   <= s_araddr;
                        size_q   <= s_arsize;
                        burst_q  <= s_arburst;
                        lock_q   <= s_arlock;
                        cache_q  <= s_arcache;
                        prot_q   <= s_arprot;
                        qos_q    <= s_arqos;
                        region_q <= s_arregion;
                        user_q   <= s_aruser;
                        rem_q    <= s_rem;
                        first_q  <= 1'b1;
                        len_q    <= 8'(beats_d - 9'd1);
                        last_q   <= (beats_d == s_rem);
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_arready) begin
                        if (last_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            addr_q  <= next_addr;
                            rem_q   <= next_rem;
                            first_q <= 1'b0;
                            len_q   <= 8'(beats_d - 9'd1);
                            last_q  <= (beats_d == next_rem);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_arready  = (state_q == S_IDLE);
    assign m_arvalid  = (state_q == S_ISSUE);
    assign m_arid     = id_q;
    assign m_araddr   = addr_q;
    assign m_arlen    = len_q;
    assign m_arsize   = size_q;
    assign m_arburst  = burst_q;
    assign m_arlock   = lock_q;
    assign m_arcache  = cache_q;
    assign m_arprot   = prot_q;
    assign m_arqos    = qos_q;
    assign m_arregion = region_q;
    assign m_aruser   = user_q;
    assign m_arfirst  = first_q;
    assign m_arlast   = last_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_ar_burst_splitter.sv
`default_nettype none
// ============================================================================
// tb_axi_ar_burst_splitter: directed bench with a burst-level reference model
// for two splitter configurations.             Revision: 1.0
// ============================================================================
module tb_axi_ar_burst_splitter;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        id;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
        logic        first;
        logic        last;
    } sub_t;

    logic        clk;
    logic        reset;
    logic        s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arlock;
    logic [3:0]  s_arcache;
    logic [2:0]  s_arprot;
    logic [3:0]  s_arqos;
    logic [3:0]  s_arregion;
    logic        s_aruser;
    logic        s_arvalid;
    logic        m_arready;

    logic        a_s_arready, a_m_arvalid, a_m_arfirst, a_m_arlast;
    logic        a_m_arid, a_m_arlock, a_m_aruser;
    logic [31:0] a_m_araddr;
    logic [7:0]  a_m_arlen;
    logic [2:0]  a_m_arsize, a_m_arprot;
    logic [1:0]  a_m_arburst;
    logic [3:0]  a_m_arcache, a_m_arqos, a_m_arregion;

    logic        b_s_arready, b_m_arvalid, b_m_arfirst, b_m_arlast;
    logic        b_m_arid, b_m_arlock, b_m_aruser;
    logic [31:0] b_m_araddr;
    logic [7:0]  b_m_arlen;
    logic [2:0]  b_m_arsize, b_m_arprot;
    logic [1:0]  b_m_arburst;
    logic [3:0]  b_m_arcache, b_m_arqos, b_m_arregion;

    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   armed        = 0;
    int   req_n        = 0;
    sub_t qa[$];
    sub_t qb[$];
    sub_t log_a[$];
    sub_t log_b[$];
    sub_t act_a, act_b;

    axi_ar_burst_splitter #(.MAX_BEATS(16), .BOUNDARY(256)) u_a (
        .clock(clk), .reset(reset),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arregion(s_arregion), .s_aruser(s_aruser),
        .s_arvalid(s_arvalid), .s_arready(a_s_arready),
        .m_arid(a_m_arid), .m_araddr(a_m_araddr), .m_arlen(a_m_arlen), .m_arsize(a_m_arsize),
        .m_arburst(a_m_arburst), .m_arlock(a_m_arlock), .m_arcache(a_m_arcache), .m_arprot(a_m_arprot),
        .m_arqos(a_m_arqos), .m_arregion(a_m_arregion), .m_aruser(a_m_aruser),
        .m_arvalid(a_m_arvalid), .m_arready(m_arready),
        .m_arfirst(a_m_arfirst), .m_arlast(a_m_arlast)
    );

    axi_ar_burst_splitter #(.MAX_BEATS(4), .BOUNDARY(4096)) u_b (
        .clock(clk), .reset(reset),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arregion(s_arregion), .s_aruser(s_aruser),
        .s_arvalid(s_arvalid), .s_arready(b_s_arready),
        .m_arid(b_m_arid), .m_araddr(b_m_araddr), .m_arlen(b_m_arlen), .m_arsize(b_m_arsize),
        .m_arburst(b_m_arburst), .m_arlock(b_m_arlock), .m_arcache(b_m_arcache), .m_arprot(b_m_arprot),
        .m_arqos(b_m_arqos), .m_arregion(b_m_arregion), .m_aruser(b_m_aruser),
        .m_arvalid(b_m_arvalid), .m_arready(m_arready),
        .m_arfirst(b_m_arfirst), .m_arlast(b_m_arlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: walk the parent burst in beats, cutting at MAX_BEATS and the boundary.
    task automatic model_push(input int k);
        int          maxb;
        int          bnd;
        int          rem;
        int          unit;
        int          b;
        int          tb;
        logic [31:0] a;
        logic [31:0] al;
        bit          first;
        sub_t        e;
        maxb  = (k == 0) ? 16 : 4;
        bnd   = (k == 0) ? 256 : 4096;
        rem   = int'(s_arlen) + 1;
        unit  = 1 << s_arsize;
        a     = s_araddr;
        first = 1'b1;
        while (rem > 0) begin
            al = a & ~(32'(unit) - 32'd1);
            if (s_arburst == 2'b01) begin
                tb = (bnd - int'(al % 32'(bnd))) / unit;
                b  = (rem < maxb) ? rem : maxb;
                if (tb < b) b = tb;
            end else if (s_arburst == 2'b00) begin
                b = (rem < maxb) ? rem : maxb;
            end else begin
                b = rem;
            end
            e = '{addr: a, len: 8'(b - 1), size: s_arsize, burst: s_arburst, id: s_arid,
                  lock: s_arlock, cache: s_arcache, prot: s_arprot, qos: s_arqos,
                  region: s_arregion, user: s_aruser, first: first, last: (b == rem)};
            if (k == 0) qa.push_back(e); else qb.push_back(e);
            rem -= b;
            if (s_arburst == 2'b01) a = al + 32'(b * unit);
            first = 1'b0;
        end
    endtask

    task automatic check_inst(input int k, input logic mv, input logic sr, input sub_t act);
        sub_t  e;
        int    n;
        string p;
        p = (k == 0) ? "a" : "b";
        n = (k == 0) ? qa.size() : qb.size();
        check({p, ".m_arvalid"}, 32'(mv), 32'(n != 0));
        check({p, ".s_arready"}, 32'(sr), 32'(n == 0));
        if (mv && n != 0) begin
            e = (k == 0) ? qa[0] : qb[0];
            check({p, ".m_araddr"}, act.addr, e.addr);
            check({p, ".m_arlen"}, 32'(act.len), 32'(e.len));
            check({p, ".m_arfirst"}, 32'(act.first), 32'(e.first));
            check({p, ".m_arlast"}, 32'(act.last), 32'(e.last));
            check({p, ".sideband"},
                  32'({act.size, act.burst, act.id, act.lock, act.cache, act.prot, act.qos, act.region, act.user}),
                  32'({e.size, e.burst, e.id, e.lock, e.cache, e.prot, e.qos, e.region, e.user}));
            if (m_arready) begin
                if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
            end
        end
        if (mv && m_arready) begin
            if (k == 0) log_a.push_back(act); else log_b.push_back(act);
        end
    endtask

    // Inputs change just after posedge, so at negedge they predict the coming edge.
    always @(negedge clk) begin
        act_a = '{addr: a_m_araddr, len: a_m_arlen, size: a_m_arsize, burst: a_m_arburst, id: a_m_arid,
                  lock: a_m_arlock, cache: a_m_arcache, prot: a_m_arprot, qos: a_m_arqos,
                  region: a_m_arregion, user: a_m_aruser, first: a_m_arfirst, last: a_m_arlast};
        act_b = '{addr: b_m_araddr, len: b_m_arlen, size: b_m_arsize, burst: b_m_arburst, id: b_m_arid,
                  lock: b_m_arlock, cache: b_m_arcache, prot: b_m_arprot, qos: b_m_arqos,
                  region: b_m_arregion, user: b_m_aruser, first: b_m_arfirst, last: b_m_arlast};
        if (reset) begin
            qa.delete();
            qb.delete();
        end else if (armed) begin
            check_inst(0, a_m_arvalid, a_s_arready, act_a);
            check_inst(1, b_m_arvalid, b_s_arready, act_b);
            if (s_arvalid && a_s_arready) model_push(0);
            if (s_arvalid && b_s_arready) model_push(1);
        end
    end

    task automatic check_log(input int k, input int idx, input logic [31:0] addr,
                             input logic [7:0] len, input logic first, input logic last);
        sub_t  e;
        int    n;
        string p;
        p = (k == 0) ? "log_a" : "log_b";
        n = (k == 0) ? log_a.size() : log_b.size();
        if (idx >= n) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s[%0d]: got no sub-burst, expected addr 0x%h len %0d", p, idx, addr, len);
        end else begin
            e = (k == 0) ? log_a[idx] : log_b[idx];
            check({p, ".addr"}, e.addr, addr);
            check({p, ".len"}, 32'(e.len), 32'(len));
            check({p, ".flags"}, 32'({e.first, e.last}), 32'({first, last}));
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            if (a_s_arready && b_s_arready && qa.size() == 0 && qb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_idle: got busy after 300 cycles, expected idle");
        end
    endtask

    task automatic present(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        log_a.delete();
        log_b.delete();
        req_n++;
        s_araddr   = a;
        s_arlen    = len;
        s_arsize   = sz;
        s_arburst  = bt;
        s_arid     = req_n[0];
        s_arlock   = req_n[1];
        s_arcache  = req_n[3:0] + 4'd3;
        s_arprot   = req_n[2:0];
        s_arqos    = ~req_n[3:0];
        s_arregion = req_n[3:0] ^ 4'h5;
        s_aruser   = ~req_n[0];
        s_arvalid  = 1'b1;
        @(posedge clk);
        #1;
        s_arvalid  = 1'b0;
        s_araddr   = 32'hDEAD_BEEF;
        s_arlen    = 8'hFF;
    endtask

    task automatic send(input logic [31:0] a, input logic [7:0] len,
                        input logic [2:0] sz, input logic [1:0] bt);
        present(a, len, sz, bt);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s_arvalid = 1'b0; s_arid = 1'b0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
        s_arburst = '0; s_arlock = 1'b0; s_arcache = '0; s_arprot = '0; s_arqos = '0;
        s_arregion = '0; s_aruser = 1'b0; m_arready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.s_arready", 32'(a_s_arready), 32'd1);
        check("reset.m_arvalid", 32'(a_m_arvalid), 32'd0);
        check("reset.m_arflags", 32'({a_m_arfirst, a_m_arlast}), 32'd0);
        check("reset.m_araddr", a_m_araddr, 32'd0);
        check("reset.m_arlen", 32'(a_m_arlen), 32'd0);
        armed = 1'b1;

        send(32'h1000, 8'd7, 3'd2, 2'b01);
        check_log(0, 0, 32'h1000, 8'd7, 1'b1, 1'b1);
        check_log(1, 0, 32'h1000, 8'd3, 1'b1, 1'b0);
        check_log(1, 1, 32'h1010, 8'd3, 1'b0, 1'b1);

        send(32'h0, 8'd39, 3'd3, 2'b01);
        check("len_split.count", 32'(log_a.size()), 32'd3);
        check_log(0, 0, 32'h000, 8'd15, 1'b1, 1'b0);
        check_log(0, 1, 32'h080, 8'd15, 1'b0, 1'b0);
        check_log(0, 2, 32'h100, 8'd7, 1'b0, 1'b1);

        send(32'hF0, 8'd15, 3'd2, 2'b01);
        check_log(0, 0, 32'h0F0, 8'd3, 1'b1, 1'b0);
        check_log(0, 1, 32'h100, 8'd11, 1'b0, 1'b1);

        send(32'h1003, 8'd20, 3'd2, 2'b01);
        check_log(0, 0, 32'h1003, 8'd15, 1'b1, 1'b0);
        check_log(0, 1, 32'h1040, 8'd4, 1'b0, 1'b1);

        send(32'h20, 8'd7, 3'd2, 2'b10);
        check("wrap.count", 32'(log_b.size()), 32'd1);
        check_log(1, 0, 32'h20, 8'd7, 1'b1, 1'b1);

        send(32'h40, 8'd9, 3'd2, 2'b00);
        check("fixed.count", 32'(log_b.size()), 32'd3);
        check_log(1, 0, 32'h40, 8'd3, 1'b1, 1'b0);
        check_log(1, 1, 32'h40, 8'd3, 1'b0, 1'b0);
        check_log(1, 2, 32'h40, 8'd1, 1'b0, 1'b1);

        // Stall the second sub-burst of a three-way length split.
        present(32'h0, 8'd39, 3'd3, 2'b01);
        @(posedge clk);
        #1;
        m_arready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall.m_araddr", a_m_araddr, 32'h80);
        check("stall.s_arready", 32'(a_s_arready), 32'd0);
        m_arready = 1'b1;
        wait_idle();
        check("stall.count", 32'(log_a.size()), 32'd3);
        check_log(0, 1, 32'h080, 8'd15, 1'b0, 1'b0);
        check_log(0, 2, 32'h100, 8'd7, 1'b0, 1'b1);

        // Reset while the second of three sub-bursts is on the bus.
        present(32'h0, 8'd39, 3'd3, 2'b01);
        @(posedge clk);
        #1;
        check("pre_reset.m_araddr", a_m_araddr, 32'h80);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_reset.m_arvalid", 32'(a_m_arvalid), 32'd0);
        check("mid_reset.s_arready", 32'(a_s_arready), 32'd1);
        check("mid_reset.m_araddr", a_m_araddr, 32'd0);
        check("mid_reset.flags", 32'({a_m_arfirst, a_m_arlast}), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_reset.count", 32'(log_a.size()), 32'd1);
        check_log(0, 0, 32'h000, 8'd15, 1'b1, 1'b0);
        check("mid_reset.idle_after", 32'(a_m_arvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
